// File: rtl/dmem_arbiter.sv
// Round-robin arbiter that serialises two masters onto one data RAM port and a GPIO write register.
// Each transaction takes three cycles: IDLE (sample/latch) -> ACCESS (gnt, RAM/GPIO strobe) -> RESP (ack).
module dmem_arbiter #(
  parameter int               MXLEN     = 32,
  parameter logic [MXLEN-1:0] GPIO_ADDR = MXLEN'(32'h0000_1000)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [2:0]       m0_ops,
  input  logic [MXLEN-1:0] m0_addr,
  input  logic [MXLEN-1:0] m0_wdata,
  output logic             m0_gnt,
  output logic             m0_ack,
  output logic [MXLEN-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [2:0]       m1_ops,
  input  logic [MXLEN-1:0] m1_addr,
  input  logic [MXLEN-1:0] m1_wdata,
  output logic             m1_gnt,
  output logic             m1_ack,
  output logic [MXLEN-1:0] m1_rdata,
  output logic             ram_en,
  output logic             ram_we,
  output logic [2:0]       ram_ops,
  output logic [MXLEN-1:0] ram_addr,
  output logic [MXLEN-1:0] ram_wdata,
  input  logic [MXLEN-1:0] ram_rdata,
  output logic             gpio_we,
  output logic [MXLEN-1:0] gpio_wdata,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_last_gnt;
  logic             r_win;
  logic             r_we;
  logic [2:0]       r_ops;
  logic [MXLEN-1:0] r_addr;
  logic [MXLEN-1:0] r_wdata;

  logic w_any;
  logic w_win;
  logic w_gpio_hit;

  assign w_any      = m0_req | m1_req;
  // A tie goes to the master that was not served last; otherwise the sole requester wins.
  assign w_win      = (m0_req & m1_req) ? ~r_last_gnt : m1_req;
  assign w_gpio_hit = (r_addr == GPIO_ADDR);
  assign dbg_state  = r_state;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:   w_next = w_any ? S_ACCESS : S_IDLE;
      S_ACCESS: w_next = S_RESP;
      S_RESP:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  // Command latch: requests are only looked at while idle, so later master changes are ignored.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_last_gnt <= 1'b1;
      r_win      <= 1'b0;
      r_we       <= 1'b0;
      r_ops      <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
    end else if (r_state == S_IDLE && w_any) begin
      r_last_gnt <= w_win;
      r_win      <= w_win;
      r_we       <= w_win ? m1_we    : m0_we;
      r_ops      <= w_win ? m1_ops   : m0_ops;
      r_addr     <= w_win ? m1_addr  : m0_addr;
      r_wdata    <= w_win ? m1_wdata : m0_wdata;
    end
  end

  always_comb begin
    m0_gnt     = 1'b0;
    m1_gnt     = 1'b0;
    m0_ack     = 1'b0;
    m1_ack     = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    ram_en     = 1'b0;
    ram_we     = 1'b0;
    ram_ops    = '0;
    ram_addr   = '0;
    ram_wdata  = '0;
    gpio_we    = 1'b0;
    gpio_wdata = '0;
    busy       = (r_state != S_IDLE);
    case (r_state)
      S_ACCESS: begin
        m0_gnt = ~r_win;
        m1_gnt = r_win;
        // The GPIO word never reaches the RAM, for loads as well as stores.
        if (w_gpio_hit) begin
          gpio_we    = r_we;
          gpio_wdata = r_we ? r_wdata : '0;
        end else begin
          ram_en    = 1'b1;
          ram_we    = r_we;
          ram_ops   = r_ops;
          ram_addr  = r_addr;
          ram_wdata = r_wdata;
        end
      end
      S_RESP: begin
        m0_ack = ~r_win;
        m1_ack = r_win;
        if (!r_we && !w_gpio_hit) begin
          if (r_win) m1_rdata = ram_rdata;
          else       m0_rdata = ram_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: queued master drivers, a registered RAM stub, and a transaction-level
// reference that predicts grant order, per-cycle strobes and load data from a shadow memory.
module tb_dmem_arbiter;

  localparam logic [31:0] GPIO = 32'h0000_1000;

  typedef struct packed {
    logic        we;
    logic [2:0]  ops;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  logic        CLK, RST;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [2:0]  m0_ops, m1_ops;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic        m0_gnt, m0_ack, m1_gnt, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic        ram_en, ram_we, gpio_we, busy;
  logic [2:0]  ram_ops;
  logic [31:0] ram_addr, ram_wdata, ram_rdata, gpio_wdata;
  logic [1:0]  dbg_state;

  dmem_arbiter #(.MXLEN(32), .GPIO_ADDR(GPIO)) dut (
    .CLK(CLK), .RST(RST),
    .m0_req(m0_req), .m0_we(m0_we), .m0_ops(m0_ops), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_ops(m1_ops), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .ram_en(ram_en), .ram_we(ram_we), .ram_ops(ram_ops), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .gpio_we(gpio_we), .gpio_wdata(gpio_wdata), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- RAM stub (environment) ----------------
  logic [31:0] stub_mem [8];
  initial ram_rdata = '0;
  always @(posedge CLK) begin
    if (ram_en) begin
      if (ram_we) stub_mem[ram_addr[4:2]] <= ram_wdata;
      else        ram_rdata <= stub_mem[ram_addr[4:2]];
    end
  end

  // ---------------- master drivers ----------------
  cmd_t q0[$];
  cmd_t q1[$];
  logic saw_gnt0 = 1'b0;
  logic saw_gnt1 = 1'b0;

  always @(posedge CLK) begin : drv
    cmd_t c;
    #1;
    if (saw_gnt0 && q0.size() > 0) void'(q0.pop_front());
    if (saw_gnt1 && q1.size() > 0) void'(q1.pop_front());
    m0_req = (q0.size() > 0);
    if (q0.size() > 0) begin
      c = q0[0];
      {m0_we, m0_ops, m0_addr, m0_wdata} = {c.we, c.ops, c.addr, c.wdata};
    end
    m1_req = (q1.size() > 0);
    if (q1.size() > 0) begin
      c = q1[0];
      {m1_we, m1_ops, m1_addr, m1_wdata} = {c.we, c.ops, c.addr, c.wdata};
    end
  end

  function automatic cmd_t mk(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    cmd_t c;
    c.we = we; c.ops = 3'($urandom_range(0, 7)); c.addr = addr; c.wdata = wdata;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    logic [31:0] a;
    a = ($urandom_range(0, 8) == 8) ? GPIO : 32'h40 + 32'(4 * $urandom_range(0, 7));
    return mk(1'($urandom_range(0, 1)), a, $urandom);
  endfunction

  // ---------------- reference model ----------------
  logic [31:0] ref_mem [logic [31:0]];
  logic [31:0] exp_q[$];
  int   cyc = 0;
  int   free_cyc = 0;
  int   c_g = -10;
  logic c_valid = 1'b0;
  logic c_w = 1'b0, c_we = 1'b0;
  logic [2:0]  c_ops = '0;
  logic [31:0] c_addr = '0, c_wdata = '0;
  logic last_served = 1'b1;

  always @(posedge CLK) begin : model
    logic w;
    cyc++;
    if (!RST) begin
      c_valid = 1'b0;
      last_served = 1'b1;
      free_cyc = cyc;
      exp_q.delete();
    end else if (cyc - 1 >= free_cyc && (m0_req || m1_req)) begin
      if (m0_req && m1_req) w = ~last_served;
      else                  w = m1_req;
      last_served = w;
      c_valid = 1'b1; c_w = w; c_g = cyc; free_cyc = cyc + 2;
      c_we    = w ? m1_we    : m0_we;
      c_ops   = w ? m1_ops   : m0_ops;
      c_addr  = w ? m1_addr  : m0_addr;
      c_wdata = w ? m1_wdata : m0_wdata;
      if (c_we) begin
        exp_q.push_back(32'h0);
        if (c_addr != GPIO) ref_mem[c_addr] = c_wdata;
      end else begin
        exp_q.push_back((c_addr == GPIO) ? 32'h0 : ref_mem[c_addr]);
      end
    end
  end

  always @(negedge CLK) begin : chk
    logic in_g, in_a, hit, e_ram, e_gpio;
    logic [31:0] e_rd;
    saw_gnt0 = m0_gnt;
    saw_gnt1 = m1_gnt;
    in_g   = RST && c_valid && (cyc == c_g);
    in_a   = RST && c_valid && (cyc == c_g + 1);
    hit    = (c_addr == GPIO);
    e_ram  = in_g && !hit;
    e_gpio = in_g && hit && c_we;
    e_rd   = '0;
    if (in_a) begin
      if (exp_q.size() > 0) e_rd = exp_q.pop_front();
      else check("exp_q_empty", 64'd1, 64'd0);
    end
    check("gnt_ack", {m0_gnt, m1_gnt, m0_ack, m1_ack},
          {in_g && !c_w, in_g && c_w, in_a && !c_w, in_a && c_w});
    check("ram_ctl", {ram_en, ram_we, ram_ops}, {e_ram, e_ram && c_we, e_ram ? c_ops : 3'd0});
    check("ram_addr", ram_addr, e_ram ? c_addr : 32'd0);
    check("ram_wdata", ram_wdata, e_ram ? c_wdata : 32'd0);
    check("gpio", {gpio_we, gpio_wdata}, {e_gpio, e_gpio ? c_wdata : 32'd0});
    check("m0_rdata", m0_rdata, (in_a && !c_w) ? e_rd : 32'd0);
    check("m1_rdata", m1_rdata, (in_a && c_w) ? e_rd : 32'd0);
    check("busy", busy, in_g || in_a);
  end

  // ---------------- stimulus ----------------
  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || m0_req || m1_req || cyc < free_cyc + 1) && n < budget) begin
      @(posedge CLK);
      n++;
    end
    if (n >= budget) check("drain_timeout", 64'd1, 64'd0);
    repeat (2) @(posedge CLK);
  endtask

  initial begin
    logic [31:0] v;
    RST = 1'b0;
    {m0_req, m0_we, m0_ops, m0_addr, m0_wdata} = '0;
    {m1_req, m1_we, m1_ops, m1_addr, m1_wdata} = '0;
    for (int i = 0; i < 8; i++) begin
      v = (i == 0) ? 32'hDEAD_BEEF : $urandom;
      stub_mem[i] = v;
      ref_mem[32'h40 + 32'(4 * i)] = v;
    end
    repeat (3) @(posedge CLK);
    #2 RST = 1'b1;

    // Simultaneous requests straight after reset: m0 first, then alternating.
    @(posedge CLK);
    q0.push_back(rand_cmd()); q0.push_back(rand_cmd());
    q1.push_back(rand_cmd()); q1.push_back(rand_cmd());
    wait_drain(60);

    // Single load of the preloaded word.
    q0.push_back(mk(1'b0, 32'h40, 32'h0));
    wait_drain(30);

    // GPIO store from m1, then a GPIO load that must return zero.
    q1.push_back(mk(1'b1, GPIO, 32'h5));
    wait_drain(30);
    q0.push_back(mk(1'b0, GPIO, 32'h0));
    wait_drain(30);

    // m0 keeps requesting while m1 asks once.
    for (int i = 0; i < 6; i++) q0.push_back(rand_cmd());
    repeat (4) @(posedge CLK);
    q1.push_back(rand_cmd());
    wait_drain(80);

    // Back-to-back store then load of the same word.
    q0.push_back(mk(1'b1, 32'h40, 32'h1234_5678));
    q0.push_back(mk(1'b0, 32'h40, 32'h0));
    wait_drain(30);

    // Random traffic with a reset landing in the middle of an ACCESS cycle.
    for (int i = 0; i < 40; i++) begin
      @(posedge CLK);
      if (q0.size() < 3 && $urandom_range(0, 3) == 0) q0.push_back(rand_cmd());
      if (q1.size() < 3 && $urandom_range(0, 3) == 0) q1.push_back(rand_cmd());
    end
    begin
      int n;
      n = 0;
      q0.push_back(rand_cmd());
      do begin
        @(posedge CLK);
        #2;
        n++;
      end while (!(m0_gnt || m1_gnt) && n < 50);
      if (n >= 50) check("rst_gnt_timeout", 64'd1, 64'd0);
      RST = 1'b0;
      #1;
      check("rst_async", {m0_gnt, m1_gnt, m0_ack, m1_ack, ram_en, gpio_we, busy}, 64'd0);
      repeat (2) @(posedge CLK);
      #2 RST = 1'b1;
    end
    wait_drain(100);

    for (int i = 0; i < 1200; i++) begin
      @(posedge CLK);
      if (q0.size() < 3 && $urandom_range(0, 2) == 0) q0.push_back(rand_cmd());
      if (q1.size() < 3 && $urandom_range(0, 2) == 0) q1.push_back(rand_cmd());
    end
    wait_drain(200);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
